// File: rtl/conv_wdma_pkg.sv
// Shared types for the conv write DMA: instruction layout, FSM states, token builder.
package conv_wdma_pkg;

  localparam int unsigned INST_ID_W   = 4;
  localparam int unsigned INST_NB_W   = 12;
  localparam int unsigned INST_ADDR_W = 16;
  // Remaining-beat counter holds up to 4096.
  localparam int unsigned REM_W       = 13;

  localparam logic [INST_ID_W-1:0] HOST_ID = 4'hF;

  // 32-bit instruction: target ID, beat count minus one, base word address.
  typedef struct packed {
    logic [INST_ID_W-1:0]   id;
    logic [INST_NB_W-1:0]   nbm1;
    logic [INST_ADDR_W-1:0] addr;
  } inst_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_e;

  // Completion token returned to the host on the instruction chain.
  function automatic logic [31:0] make_token(input logic [INST_NB_W-1:0] nbm1, input logic err);
    return {HOST_ID, nbm1, 15'b0, err};
  endfunction

endpackage

// File: rtl/conv_wdma_if.sv
// Bundle of the write DMA's instruction, result-stream and memory-write handshakes.
interface conv_wdma_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned IW = 32,
  parameter int unsigned AW = 16
);
  logic [IW-1:0] inst_m_data;
  logic          inst_m_valid;
  logic          inst_m_ready;
  logic [IW-1:0] inst_s_data;
  logic          inst_s_valid;
  logic          inst_s_ready;
  logic [DW-1:0] d_data;
  logic          d_first;
  logic          d_last;
  logic          d_valid;
  logic          d_ready;
  logic [AW-1:0] mw_addr;
  logic [7:0]    mw_len;
  logic          mw_avalid;
  logic          mw_aready;
  logic [DW-1:0] mw_data;
  logic          mw_dlast;
  logic          mw_dvalid;
  logic          mw_dready;
  logic          mw_bvalid;
  logic          mw_bready;

  // DMA side.
  modport slave (
    input  inst_m_data, inst_m_valid, output inst_m_ready,
    output inst_s_data, inst_s_valid, input  inst_s_ready,
    input  d_data, d_first, d_last, d_valid, output d_ready,
    output mw_addr, mw_len, mw_avalid, input mw_aready,
    output mw_data, mw_dlast, mw_dvalid, input mw_dready,
    input  mw_bvalid, output mw_bready
  );

  // Environment side.
  modport master (
    output inst_m_data, inst_m_valid, input  inst_m_ready,
    input  inst_s_data, inst_s_valid, output inst_s_ready,
    output d_data, d_first, d_last, d_valid, input d_ready,
    input  mw_addr, mw_len, mw_avalid, output mw_aready,
    input  mw_data, mw_dlast, mw_dvalid, output mw_dready,
    output mw_bvalid, input mw_bready
  );
endinterface

// File: rtl/conv_wdma_axi_frs.sv
// Forward register slice: one registered stage, full throughput.
module axi_frs #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);
  logic [W-1:0] data_q;
  logic         valid_q;

  assign s_ready_o = !valid_q || m_ready_i;
  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;

  // Load a new word whenever the slot is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (s_ready_o) begin
      valid_q <= s_valid_i;
      if (s_valid_i) data_q <= s_data_i;
    end
  end
endmodule

// File: rtl/conv_wdma.sv
// Convolution write DMA: drains a result stream into BL-aligned memory bursts, then issues a token.
// Optional build macro CONV_WDMA_FRAMECHK_EN enables first/last framing checks (token bit0).
module conv_wdma
  import conv_wdma_pkg::*;
#(
  parameter int unsigned DW = 64,
  parameter int unsigned IW = 32,
  parameter int unsigned AW = 16,
  parameter int unsigned BL = 16,
  parameter logic [3:0]  ID = 4'h0
) (
  input logic        clk,
  input logic        rst_n,
  conv_wdma_if.slave bus_io
);
  localparam int unsigned BLW = $clog2(BL);

  // Beats-1 of the next burst: limited by what is left and by the BL boundary.
  function automatic logic [7:0] burst_len_m1(input logic [AW-1:0] a, input logic [REM_W-1:0] r);
    logic [REM_W-1:0] room;
    room = REM_W'(BL) - REM_W'(a[BLW-1:0]);
    return (r < room) ? 8'(r - REM_W'(1)) : 8'(room - REM_W'(1));
  endfunction

  state_e               state_q;
  logic [AW-1:0]        addr_q;
  logic [REM_W-1:0]     rem_q;
  logic [INST_NB_W-1:0] nb_q;
  logic [7:0]           len_q;
  logic [7:0]           beat_q;
  logic                 err_q;

  inst_t            inst_c;
  logic             id_hit_c;
  logic             inst_fire_c;
  logic             beat_fire_c;
  logic             last_beat_c;
  logic             frame_bad_c;
  logic [REM_W-1:0] blen_c;
  logic [AW-1:0]    addr_nxt_c;
  logic [REM_W-1:0] rem_nxt_c;
  logic             frs_valid_c;
  logic             frs_ready_c;
  logic [IW-1:0]    frs_data_c;

  assign inst_c      = bus_io.inst_m_data;
  assign id_hit_c    = inst_c.id == ID;
  assign inst_fire_c = bus_io.inst_m_valid && bus_io.inst_m_ready;
  assign beat_fire_c = (state_q == ST_DATA) && bus_io.d_valid && bus_io.mw_dready;
  assign last_beat_c = beat_q == len_q;
  assign blen_c      = REM_W'(len_q) + REM_W'(1);
  assign addr_nxt_c  = addr_q + AW'(blen_c);
  assign rem_nxt_c   = rem_q - blen_c;

  // Port decodes; the data phase is a zero-latency pass-through.
  assign bus_io.inst_m_ready = (state_q == ST_IDLE) && frs_ready_c;
  assign bus_io.mw_addr      = addr_q;
  assign bus_io.mw_len       = len_q;
  assign bus_io.mw_avalid    = state_q == ST_ADDR;
  assign bus_io.mw_data      = DW'(bus_io.d_data);
  assign bus_io.mw_dvalid    = (state_q == ST_DATA) && bus_io.d_valid;
  assign bus_io.mw_dlast     = (state_q == ST_DATA) && last_beat_c;
  assign bus_io.d_ready      = (state_q == ST_DATA) && bus_io.mw_dready;
  assign bus_io.mw_bready    = state_q == ST_RESP;

  // Out slot carries forwarded instructions in IDLE and the token in DONE, never both.
  assign frs_valid_c = ((state_q == ST_IDLE) && bus_io.inst_m_valid && !id_hit_c) ||
                       (state_q == ST_DONE);
  assign frs_data_c  = (state_q == ST_DONE) ? IW'(make_token(nb_q, err_q)) : bus_io.inst_m_data;

  axi_frs #(.W(IW)) u_out_frs (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (frs_data_c),
    .s_valid_i (frs_valid_c),
    .s_ready_o (frs_ready_c),
    .m_data_o  (bus_io.inst_s_data),
    .m_valid_o (bus_io.inst_s_valid),
    .m_ready_i (bus_io.inst_s_ready)
  );

`ifdef CONV_WDMA_FRAMECHK_EN
  logic [INST_NB_W-1:0] gbeat_q;

  assign frame_bad_c = (bus_io.d_first != (gbeat_q == '0)) ||
                       (bus_io.d_last != (gbeat_q == nb_q));

  // Global beat index across all bursts of the current instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gbeat_q <= '0;
    end else if (inst_fire_c && id_hit_c) begin
      gbeat_q <= '0;
    end else if (beat_fire_c) begin
      gbeat_q <= gbeat_q + INST_NB_W'(1);
    end
  end
`else
  logic unused_frame_c;

  assign frame_bad_c    = 1'b0;
  assign unused_frame_c = bus_io.d_first ^ bus_io.d_last;
`endif

  // Instruction sequencing: address phase, data phase, response, repeat until all beats written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      nb_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (inst_fire_c && id_hit_c) begin
            addr_q  <= AW'(inst_c.addr);
            nb_q    <= inst_c.nbm1;
            rem_q   <= REM_W'(inst_c.nbm1) + REM_W'(1);
            len_q   <= burst_len_m1(AW'(inst_c.addr), REM_W'(inst_c.nbm1) + REM_W'(1));
            beat_q  <= '0;
            err_q   <= 1'b0;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus_io.mw_aready) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_fire_c) begin
            if (frame_bad_c) err_q <= 1'b1;
            if (last_beat_c) begin
              beat_q  <= '0;
              state_q <= ST_RESP;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (bus_io.mw_bvalid) begin
            addr_q <= addr_nxt_c;
            rem_q  <= rem_nxt_c;
            if (rem_nxt_c == '0) begin
              state_q <= ST_DONE;
            end else begin
              len_q   <= burst_len_m1(addr_nxt_c, rem_nxt_c);
              state_q <= ST_ADDR;
            end
          end
        end
        ST_DONE: begin
          if (frs_ready_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_wdma.sv
// Scoreboard bench for conv_wdma: a burst/beat/token model feeds queues checked by bus monitors.
module tb_conv_wdma;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned BL = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_wdma_if #(.DW(DW), .IW(IW), .AW(AW)) bus ();

  conv_wdma #(.DW(DW), .IW(IW), .AW(AW), .BL(BL), .ID(4'h0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_burst[$];   // {addr, len}
  logic [64:0] exp_beat[$];    // {dlast, data}
  logic [31:0] exp_out[$];

  bit stall = 1'b0;
  bit abort = 1'b0;
  bit b_ack = 1'b0;
  int beats_seen = 0;
  int dlast_cnt = 0;
  int b_cnt = 0;
  int avalid_cycles = 0;
  int seq = 0;

  logic [23:0] eb;
  logic [64:0] ed;
  logic [31:0] eo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int k);
    return {32'(seq), 32'(k)};
  endfunction

  // Reference model: split into BL-aligned bursts and queue everything the DUT should emit.
  task automatic expect_inst(input logic [15:0] base, input int n, input bit err);
    int rem;
    int k;
    int room;
    int bl;
    logic [15:0] a;
    rem = n;
    k = 0;
    a = base;
    while (rem > 0) begin
      room = int'(BL) - int'(a % 16'(BL));
      bl = (rem < room) ? rem : room;
      exp_burst.push_back({a, 8'(bl - 1)});
      for (int j = 0; j < bl; j++) begin
        exp_beat.push_back({(j == bl - 1), beat_data(k)});
        k++;
      end
      a = a + 16'(bl);
      rem -= bl;
    end
    exp_out.push_back({4'hF, 12'(n - 1), 15'b0, err});
  endtask

  // Monitors, sampled on the falling edge while inputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mw_avalid) avalid_cycles++;
      if (bus.mw_avalid && bus.mw_aready) begin
        if (exp_burst.size() == 0) begin
          check_eq("burst_unexpected", 64'(bus.mw_addr), 64'hDEAD);
        end else begin
          eb = exp_burst.pop_front();
          check_eq("burst_addr", 64'(bus.mw_addr), 64'(eb[23:8]));
          check_eq("burst_len", 64'(bus.mw_len), 64'(eb[7:0]));
        end
      end
      if (bus.mw_dvalid && bus.mw_dready) begin
        beats_seen++;
        if (bus.mw_dlast) dlast_cnt++;
        if (exp_beat.size() == 0) begin
          check_eq("beat_unexpected", bus.mw_data, 64'hDEAD);
        end else begin
          ed = exp_beat.pop_front();
          check_eq("beat_data", bus.mw_data, ed[63:0]);
          check_eq("beat_dlast", 64'(bus.mw_dlast), 64'(ed[64]));
        end
      end
      if (bus.mw_bvalid && bus.mw_bready) b_ack = 1'b1;
      if (bus.inst_s_valid && bus.inst_s_ready) begin
        if (exp_out.size() == 0) begin
          check_eq("out_unexpected", 64'(bus.inst_s_data), 64'hDEAD);
        end else begin
          eo = exp_out.pop_front();
          check_eq("inst_s_data", 64'(bus.inst_s_data), 64'(eo));
        end
      end
    end
  end

  // Memory side and downstream readiness, with optional random stalls.
  always @(posedge clk) begin
    #1;
    bus.mw_aready    = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    bus.mw_dready    = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.inst_s_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (b_ack) begin
      bus.mw_bvalid = 1'b0;
      b_ack = 1'b0;
    end else if (!bus.mw_bvalid && dlast_cnt > b_cnt && (!stall || $urandom_range(0, 1) == 1)) begin
      bus.mw_bvalid = 1'b1;
      b_cnt++;
    end
  end

  task automatic send_inst(input logic [31:0] inst);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.inst_m_data  = inst;
    bus.inst_m_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.inst_m_ready) break;
      guard++;
      if (guard > 2000) begin
        check_eq("inst_timeout", 64'(guard), 64'(0));
        break;
      end
    end
    @(posedge clk); #1;
    bus.inst_m_valid = 1'b0;
  endtask

  task automatic send_stream(input int n, input int bad_idx);
    int i;
    int guard;
    bit pending;
    i = 0;
    guard = 0;
    pending = 1'b0;
    while (i < n && !abort) begin
      @(posedge clk); #1;
      if (abort) break;
      if (!pending && stall && $urandom_range(0, 2) == 0) begin
        bus.d_valid = 1'b0;
      end else begin
        bus.d_valid = 1'b1;
        bus.d_data  = beat_data(i);
        bus.d_first = (i == 0);
        bus.d_last  = (bad_idx >= 0) ? (i == bad_idx) : (i == n - 1);
        pending = 1'b1;
      end
      @(negedge clk);
      if (bus.d_valid && bus.d_ready) begin
        i++;
        pending = 1'b0;
      end
      guard++;
      if (guard > 5000) begin
        check_eq("stream_timeout", 64'(i), 64'(n));
        break;
      end
    end
    @(posedge clk); #1;
    bus.d_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_burst.size() + exp_beat.size() + exp_out.size()) != 0 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_pending", 64'(exp_burst.size() + exp_beat.size() + exp_out.size()), 64'(0));
    repeat (4) @(negedge clk);
  endtask

  task automatic run_dma(input logic [15:0] base, input int n, input int bad_idx);
    bit err;
`ifdef CONV_WDMA_FRAMECHK_EN
    err = (bad_idx >= 0);
`else
    err = 1'b0;
`endif
    seq++;
    expect_inst(base, n, err);
    send_inst({4'h0, 12'(n - 1), base});
    send_stream(n, bad_idx);
    drain();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_inst_m_ready", 64'(bus.inst_m_ready), 64'(1));
    check_eq("rst_inst_s_valid", 64'(bus.inst_s_valid), 64'(0));
    check_eq("rst_inst_s_data", 64'(bus.inst_s_data), 64'(0));
    check_eq("rst_mw_avalid", 64'(bus.mw_avalid), 64'(0));
    check_eq("rst_mw_dvalid", 64'(bus.mw_dvalid), 64'(0));
    check_eq("rst_d_ready", 64'(bus.d_ready), 64'(0));
    check_eq("rst_mw_bready", 64'(bus.mw_bready), 64'(0));
    check_eq("rst_mw_addr", 64'(bus.mw_addr), 64'(0));
    check_eq("rst_mw_len", 64'(bus.mw_len), 64'(0));
  endtask

  initial begin
    logic [31:0] fwd;
    rst_n            = 1'b0;
    bus.inst_m_data  = '0;
    bus.inst_m_valid = 1'b0;
    bus.d_data       = '0;
    bus.d_first      = 1'b0;
    bus.d_last       = 1'b0;
    bus.d_valid      = 1'b0;
    bus.mw_aready    = 1'b0;
    bus.mw_dready    = 1'b0;
    bus.mw_bvalid    = 1'b0;
    bus.inst_s_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two bursts split at the 16-beat boundary.
    run_dma(16'h0005, 20, -1);

    // Foreign ID is forwarded untouched and starts no memory traffic.
    avalid_cycles = 0;
    exp_out.push_back({4'h3, 12'hABC, 16'h1234});
    send_inst({4'h3, 12'hABC, 16'h1234});
    drain();
    check_eq("fwd_no_avalid", 64'(avalid_cycles), 64'(0));
    check_eq("fwd_idle_ready", 64'(bus.inst_m_ready), 64'(1));

    // Address wraps at the top of memory.
    run_dma(16'hFFFE, 4, -1);

    // Random backpressure on every handshake with mixed traffic.
    stall = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        fwd = $urandom();
        fwd[31:28] = 4'(1 + $urandom_range(0, 14));
        exp_out.push_back(fwd);
        send_inst(fwd);
        drain();
      end else if ($urandom_range(0, 2) == 0) begin
        run_dma(16'hFFF0 + 16'($urandom_range(0, 15)), 1 + $urandom_range(0, 39), -1);
      end else begin
        run_dma(16'($urandom()), 1 + $urandom_range(0, 39), -1);
      end
    end
    stall = 1'b0;

    // Misplaced last marker: all beats still written, error reported when checking is built in.
    run_dma(16'h0100, 5, 2);

    // Reset in the middle of a data phase.
    seq++;
    beats_seen = 0;
    expect_inst(16'h0000, 10, 1'b0);
    send_inst({4'h0, 12'd9, 16'h0000});
    fork
      send_stream(10, -1);
      begin
        int g;
        g = 0;
        while (beats_seen < 3 && g < 2000) begin
          @(negedge clk);
          g++;
        end
        check_eq("rst_mid_reached", 64'(beats_seen >= 3), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check_reset_outputs();
        exp_burst.delete();
        exp_beat.delete();
        exp_out.delete();
        bus.mw_bvalid = 1'b0;
        b_ack = 1'b0;
        dlast_cnt = 0;
        b_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    run_dma(16'h0020, 8, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
